// File: rtl/cpu_clock_controller.sv
// cpu_clock_controller: board-clock-domain clock-enable generator for the
// microprogrammed processor. Produces one-cycle cpu_ce pulses in stop, run,
// single-step and burst modes from a runtime-loadable prescaler, parks the
// processor on HALT, and counts issued pulses for the display.
module cpu_clock_controller #(
    parameter int DIV_WIDTH       = 24,
    parameter int DEFAULT_DIV     = 2000000,
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int DEBOUNCE_WIDTH  = 18
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           mode,
    input  logic [DIV_WIDTH-1:0] div_value,
    input  logic                 load_div,
    input  logic                 step_btn,
    input  logic [7:0]           burst_count,
    input  logic                 halt,
    output logic                 cpu_ce,
    output logic                 cpu_clk_out,
    output logic [2:0]           state,
    output logic [15:0]          tick_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_BURST  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    localparam logic [1:0] MODE_STOP  = 2'b00;
    localparam logic [1:0] MODE_RUN   = 2'b01;
    localparam logic [1:0] MODE_STEP  = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    localparam logic [DIV_WIDTH-1:0]      DIV_RESET = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0]      DIV_ONE   = DIV_WIDTH'(1);
    localparam logic [DEBOUNCE_WIDTH-1:0] DB_LAST   = DEBOUNCE_WIDTH'(DEBOUNCE_CYCLES - 1);

    state_t                  cur_state;
    state_t                  nxt_state;
    logic [DIV_WIDTH-1:0]    div_reg;
    logic [DIV_WIDTH-1:0]    presc;
    logic                    presc_wrap;
    logic                    tick;
    logic [1:0]              sync_ff;
    logic                    btn_sync;
    logic                    db_level;
    logic                    db_prev;
    logic [DEBOUNCE_WIDTH-1:0] db_cnt;
    logic                    step_req;
    logic [7:0]              remaining;
    logic [7:0]              rem_nxt;
    logic                    ce_nxt;

    assign state = cur_state;

    // Divide register: a zero ratio is clamped to one so the prescaler never stalls.
    always_ff @(posedge clk) begin
        if (reset)
            div_reg <= DIV_RESET;
        else if (load_div)
            div_reg <= (div_value == '0) ? DIV_ONE : div_value;
    end

    // Wrap compare uses >= so a ratio shrunk below the current count recovers at once.
    assign presc_wrap = (presc >= (div_reg - DIV_ONE));
    // The load cycle never ticks: the restarted prescaler owns the next pulse.
    assign tick       = presc_wrap && !load_div;

    // Free-running prescaler, restarted by reset or a ratio load.
    always_ff @(posedge clk) begin
        if (reset || load_div)
            presc <= '0;
        else if (presc_wrap)
            presc <= '0;
        else
            presc <= presc + DIV_ONE;
    end

    // Two-flop synchroniser for the asynchronous push-button.
    always_ff @(posedge clk) begin
        if (reset)
            sync_ff <= 2'b00;
        else
            sync_ff <= {sync_ff[0], step_btn};
    end

    assign btn_sync = sync_ff[1];

    // Debounce: the level follows the input only after a full run of disagreeing cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_level <= 1'b0;
            db_cnt   <= '0;
        end else if (btn_sync == db_level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_level <= btn_sync;
            db_cnt   <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Delayed debounced level for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset)
            db_prev <= 1'b0;
        else
            db_prev <= db_level;
    end

    assign step_req = db_level && !db_prev;

    // Next-state and pulse decision; halt outranks mode exits, which outrank ticks.
    always_comb begin
        nxt_state = cur_state;
        rem_nxt   = remaining;
        ce_nxt    = 1'b0;
        if (halt && (cur_state != S_HALTED)) begin
            nxt_state = S_HALTED;
        end else begin
            case (cur_state)
                S_IDLE: begin
                    if (mode == MODE_RUN) begin
                        nxt_state = S_RUN;
                    end else if (step_req && (mode == MODE_STEP)) begin
                        nxt_state = S_STEP;
                    end else if (step_req && (mode == MODE_BURST) && (burst_count != 8'd0)) begin
                        nxt_state = S_BURST;
                        rem_nxt   = burst_count;
                    end
                end
                S_RUN: begin
                    if (mode != MODE_RUN)
                        nxt_state = S_IDLE;
                    else if (tick)
                        ce_nxt = 1'b1;
                end
                S_STEP: begin
                    ce_nxt    = 1'b1;
                    nxt_state = S_IDLE;
                end
                S_BURST: begin
                    if (remaining == 8'd0) begin
                        nxt_state = S_IDLE;
                    end else if (tick) begin
                        ce_nxt  = 1'b1;
                        rem_nxt = remaining - 8'd1;
                        if (remaining == 8'd1)
                            nxt_state = S_IDLE;
                    end
                end
                S_HALTED: begin
                    if (!halt && (mode == MODE_STOP))
                        nxt_state = S_IDLE;
                end
                default: nxt_state = S_IDLE;
            endcase
        end
    end

    // State, burst counter and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state   <= S_IDLE;
            remaining   <= 8'd0;
            cpu_ce      <= 1'b0;
            cpu_clk_out <= 1'b0;
            tick_count  <= 16'd0;
        end else begin
            cur_state <= nxt_state;
            remaining <= rem_nxt;
            cpu_ce    <= ce_nxt;
            if (ce_nxt) begin
                cpu_clk_out <= ~cpu_clk_out;
                tick_count  <= tick_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Bench for cpu_clock_controller: directed scenarios plus randomised divider
// reloads, checked cycle by cycle against pulse times derived arithmetically.
module tb_cpu_clock_controller;

    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    mode;
    logic [DW-1:0] div_value;
    logic          load_div;
    logic          step_btn;
    logic [7:0]    burst_count;
    logic          halt;
    logic          cpu_ce;
    logic          cpu_clk_out;
    logic [2:0]    state;
    logic [15:0]   tick_count;

    int passed = 0;
    int total  = 0;

    logic [15:0] cnt_m;
    logic        clk_m;

    cpu_clock_controller #(
        .DIV_WIDTH(DW),
        .DEFAULT_DIV(4),
        .DEBOUNCE_CYCLES(3),
        .DEBOUNCE_WIDTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mode(mode),
        .div_value(div_value),
        .load_div(load_div),
        .step_btn(step_btn),
        .burst_count(burst_count),
        .halt(halt),
        .cpu_ce(cpu_ce),
        .cpu_clk_out(cpu_clk_out),
        .state(state),
        .tick_count(tick_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Advance the model by one expected-pulse decision.
    task automatic model_pulse(input bit e);
        if (e) begin
            cnt_m = cnt_m + 16'd1;
            clk_m = ~clk_m;
        end
    endtask

    initial begin
        int d;
        int dm;
        int nc;
        int seen;
        int extra;
        bit e;

        reset = 1'b1; mode = 2'b00; div_value = '0; load_div = 1'b0;
        step_btn = 1'b0; burst_count = 8'd0; halt = 1'b0;
        cnt_m = 16'd0; clk_m = 1'b0;
        cyc_wait(3);
        check("reset_ce", 32'(cpu_ce), 0);
        check("reset_clk_out", 32'(cpu_clk_out), 0);
        check("reset_state", 32'(state), 0);
        check("reset_tick_count", 32'(tick_count), 0);

        // Run from reset with the default ratio of 4.
        reset = 1'b0; mode = 2'b01;
        for (int n = 1; n <= 20; n++) begin
            cyc_wait(1);
            e = (n % 4 == 0);
            model_pulse(e);
            check("run_ce", 32'(cpu_ce), 32'(e));
            check("run_clk_out", 32'(cpu_clk_out), 32'(clk_m));
        end
        check("run_tick_count_5", 32'(tick_count), 5);

        // Ratio reloads while running: first clamps 0 to 1, last loads 6.
        for (int t = 0; t < 7; t++) begin
            if (t == 0)      d = 0;
            else if (t == 6) d = 6;
            else             d = $urandom_range(1, 7);
            dm = (d == 0) ? 1 : d;
            div_value = DW'(d); load_div = 1'b1;
            cyc_wait(1);
            load_div = 1'b0;
            check("reload_ce_at_load", 32'(cpu_ce), 0);
            nc = $urandom_range(dm + 1, 18);
            for (int n = 1; n <= nc; n++) begin
                cyc_wait(1);
                e = (n % dm == 0);
                model_pulse(e);
                check("reload_ce", 32'(cpu_ce), 32'(e));
            end
            check("reload_tick_count", 32'(tick_count), 32'(cnt_m));
            check("reload_clk_out", 32'(cpu_clk_out), 32'(clk_m));
        end

        // Halt raised in a tick cycle suppresses that pulse.
        div_value = DW'(4); load_div = 1'b1;
        cyc_wait(1);
        load_div = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            cyc_wait(1);
            check("pre_halt_ce", 32'(cpu_ce), 0);
        end
        halt = 1'b1;
        cyc_wait(1);
        check("halt_ce_suppressed", 32'(cpu_ce), 0);
        check("halt_state", 32'(state), 4);
        check("halt_tick_count", 32'(tick_count), 32'(cnt_m));
        mode = 2'b00;
        cyc_wait(2);
        check("halt_hold_state", 32'(state), 4);
        check("halt_hold_ce", 32'(cpu_ce), 0);
        halt = 1'b0;
        cyc_wait(1);
        check("halt_release_state", 32'(state), 0);

        // Leaving run in a tick cycle issues no pulse.
        mode = 2'b01; div_value = DW'(4); load_div = 1'b1;
        cyc_wait(1);
        load_div = 1'b0;
        cyc_wait(3);
        mode = 2'b00;
        cyc_wait(1);
        check("mode_exit_ce", 32'(cpu_ce), 0);
        check("mode_exit_state", 32'(state), 0);

        // Burst of 3 at ratio 4, with a second press landing mid-burst.
        reset = 1'b1;
        cyc_wait(1);
        reset = 1'b0;
        cnt_m = 16'd0; clk_m = 1'b0;
        check("burst_pre_tick_count", 32'(tick_count), 0);
        mode = 2'b11; burst_count = 8'd3; div_value = DW'(4); load_div = 1'b1; step_btn = 1'b1;
        cyc_wait(1);
        load_div = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            cyc_wait(1);
            if (n == 4)  step_btn = 1'b0;
            if (n == 9)  step_btn = 1'b1;
            if (n == 20) step_btn = 1'b0;
            e = (n == 8) || (n == 12) || (n == 16);
            model_pulse(e);
            check("burst_ce", 32'(cpu_ce), 32'(e));
            if (n == 5 || n == 15) check("burst_state_active", 32'(state), 3);
            if (n == 16)           check("burst_state_done", 32'(state), 0);
        end
        check("burst_tick_count", 32'(tick_count), 3);
        check("burst_end_state", 32'(state), 0);

        // Bouncing button then a stable press: exactly one step pulse.
        mode = 2'b10; burst_count = 8'd0;
        step_btn = 1'b1; cyc_wait(1);
        step_btn = 1'b0; cyc_wait(1);
        step_btn = 1'b1; cyc_wait(1);
        step_btn = 1'b0; cyc_wait(1);
        step_btn = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            cyc_wait(1);
            e = (n == 7);
            model_pulse(e);
            check("step_ce", 32'(cpu_ce), 32'(e));
            if (n == 6) check("step_state", 32'(state), 2);
            if (n == 7) check("step_return_state", 32'(state), 0);
        end
        check("step_tick_count", 32'(tick_count), 32'(cnt_m));

        // Reset two pulses into a 200-tick burst.
        step_btn = 1'b0;
        cyc_wait(8);
        mode = 2'b11; burst_count = 8'd200; step_btn = 1'b1;
        seen = 0;
        for (int k = 0; k < 200 && seen < 2; k++) begin
            cyc_wait(1);
            if (state == 3'd3) step_btn = 1'b0;
            if (cpu_ce) seen++;
        end
        check("burst200_two_pulses", 32'(seen), 2);
        reset = 1'b1;
        cyc_wait(1);
        reset = 1'b0;
        check("midreset_ce", 32'(cpu_ce), 0);
        check("midreset_tick_count", 32'(tick_count), 0);
        check("midreset_state", 32'(state), 0);
        check("midreset_clk_out", 32'(cpu_clk_out), 0);
        extra = 0;
        for (int n = 1; n <= 40; n++) begin
            cyc_wait(1);
            if (cpu_ce !== 1'b0) extra++;
        end
        check("midreset_no_pulses", 32'(extra), 0);
        check("midreset_idle", 32'(state), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
